// File: rtl/arb_trigger_pkg.sv
// Shared types for the arbitrage order trigger: FSM states, queued
// opportunity entry, route codes and a saturating counter helper.
package arb_trigger_pkg;

  // Entry field widths; the top-level PATH_WIDTH/PROFIT_WIDTH must match.
  localparam int ARB_PATH_W   = 3;
  localparam int ARB_PROFIT_W = 32;

  // Route codes as produced by the detection stage.
  localparam logic [ARB_PATH_W-1:0] PATH_CB_BN  = 3'b001;  // buy Coinbase, sell Binance
  localparam logic [ARB_PATH_W-1:0] PATH_BN_CB  = 3'b010;  // buy Binance, sell Coinbase
  localparam logic [ARB_PATH_W-1:0] PATH_BN_OKX = 3'b011;  // buy Binance, sell OKX

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_COOLDOWN = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ARB_PATH_W-1:0]   path;
    logic [ARB_PROFIT_W-1:0] profit;
  } opp_entry_t;

  // Increment when enabled, holding at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/arb_opp_fifo.sv
// Shallow opportunity queue: synchronous, power-of-two depth, with flush
// and same-cycle push/pop (also legal when full, since the pop frees a slot).
module arb_opp_fifo
  import arb_trigger_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  opp_entry_t i_push_data,
  input  logic       i_pop,
  output opp_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = AW + 1;

  opp_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == CW'(0));
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/arb_order_trigger.sv
// Arbitrage order trigger: qualifies opportunities by profit, queues them,
// rate-limits with a token bucket plus cooldown, and issues one order at a
// time over valid/ready, tracking it until a matching ack or a timeout.
module arb_order_trigger
  import arb_trigger_pkg::*;
#(
  parameter int PROFIT_WIDTH        = ARB_PROFIT_W,
  parameter int PATH_WIDTH          = ARB_PATH_W,
  parameter int FIFO_DEPTH          = 4,
  parameter int MIN_PROFIT_BPS      = 10,
  parameter int TOKEN_MAX           = 8,
  parameter int TOKEN_REFILL_CYCLES = 30000,
  parameter int ORDER_TIMEOUT       = 3000,
  parameter int COOLDOWN_CYCLES     = 300,
  parameter int SEQ_WIDTH           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    kill_switch,
  input  logic                    opp_valid,
  input  logic [PROFIT_WIDTH-1:0] opp_profit_bps,
  input  logic [PATH_WIDTH-1:0]   opp_path,
  output logic                    ord_valid,
  input  logic                    ord_ready,
  output logic [PATH_WIDTH-1:0]   ord_path,
  output logic [PROFIT_WIDTH-1:0] ord_profit_bps,
  output logic [SEQ_WIDTH-1:0]    ord_seq,
  input  logic                    ack_valid,
  input  logic [SEQ_WIDTH-1:0]    ack_seq,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic [3:0]              tokens,
  output logic [31:0]             orders_sent,
  output logic [31:0]             drops_low,
  output logic [31:0]             drops_full,
  output logic [31:0]             timeouts
);

  localparam int TW = (ORDER_TIMEOUT < 2) ? 1 : $clog2(ORDER_TIMEOUT + 1);
  localparam int CW = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam int RW = (TOKEN_REFILL_CYCLES < 2) ? 1 : $clog2(TOKEN_REFILL_CYCLES);

  // With no cooldown configured the FSM skips the COOLDOWN state entirely.
  localparam arb_state_t ST_AFTER_ORDER = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;

  arb_state_t              r_state;
  logic                    r_ord_valid;
  logic [PATH_WIDTH-1:0]   r_ord_path;
  logic [PROFIT_WIDTH-1:0] r_ord_profit;
  logic [SEQ_WIDTH-1:0]    r_ord_seq;
  logic [SEQ_WIDTH-1:0]    r_out_seq;
  logic                    r_busy;
  logic                    r_timeout_pulse;
  logic [TW-1:0]           r_timer;
  logic [CW-1:0]           r_cool;
  logic [3:0]              r_tokens;
  logic [RW-1:0]           r_refill_cnt;
  logic [31:0]             r_orders_sent;
  logic [31:0]             r_drops_low;
  logic [31:0]             r_drops_full;
  logic [31:0]             r_timeouts;

  opp_entry_t w_push_entry;
  opp_entry_t w_head;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_low;
  logic       w_pop;
  logic       w_push;
  logic       w_drop_full;
  logic       w_hs;
  logic       w_refill;
  logic       w_ack_match;
  logic       w_timer_done;
  logic       w_timeout;

  assign w_push_entry.path   = opp_path;
  assign w_push_entry.profit = opp_profit_bps;

  assign w_low        = opp_valid && (opp_profit_bps < PROFIT_WIDTH'(MIN_PROFIT_BPS));
  assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty && (r_tokens != 4'd0) &&
                        enable && !kill_switch;
  // Kill suppresses intake silently: those opportunities are not counted as drops.
  assign w_push       = opp_valid && !w_low && !kill_switch && (!w_fifo_full || w_pop);
  assign w_drop_full  = opp_valid && !w_low && !kill_switch && w_fifo_full && !w_pop;
  assign w_hs         = r_ord_valid && ord_ready;
  assign w_refill     = (r_refill_cnt == RW'(TOKEN_REFILL_CYCLES - 1));
  assign w_ack_match  = ack_valid && (ack_seq == r_out_seq);
  // Timer is loaded with ORDER_TIMEOUT-1, so it reads 0 in the pulse cycle.
  assign w_timer_done = (r_timer <= TW'(1));
  assign w_timeout    = (r_state == ST_WAIT_ACK) && !w_ack_match && w_timer_done;

  arb_opp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (kill_switch),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Token bucket: periodic refill up to TOKEN_MAX, one token per handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tokens     <= 4'(TOKEN_MAX);
      r_refill_cnt <= '0;
    end else begin
      r_refill_cnt <= w_refill ? '0 : (r_refill_cnt + RW'(1));
      if (w_hs && w_refill) begin
        r_tokens <= r_tokens;
      end else if (w_hs) begin
        r_tokens <= r_tokens - 4'd1;
      end else if (w_refill && (r_tokens < 4'(TOKEN_MAX))) begin
        r_tokens <= r_tokens + 4'd1;
      end else begin
        r_tokens <= r_tokens;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_orders_sent <= 32'd0;
      r_drops_low   <= 32'd0;
      r_drops_full  <= 32'd0;
      r_timeouts    <= 32'd0;
    end else begin
      r_orders_sent <= sat_inc32(r_orders_sent, w_hs);
      r_drops_low   <= sat_inc32(r_drops_low, w_low);
      r_drops_full  <= sat_inc32(r_drops_full, w_drop_full);
      r_timeouts    <= sat_inc32(r_timeouts, w_timeout);
    end
  end

  // Order FSM with registered request payload, busy and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_ord_valid     <= 1'b0;
      r_ord_path      <= '0;
      r_ord_profit    <= '0;
      r_ord_seq       <= '0;
      r_out_seq       <= '0;
      r_busy          <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_timer         <= '0;
      r_cool          <= '0;
    end else begin
      r_timeout_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state      <= ST_ISSUE;
            r_ord_valid  <= 1'b1;
            r_ord_path   <= w_head.path;
            r_ord_profit <= w_head.profit;
            r_busy       <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (w_hs) begin
            r_ord_valid <= 1'b0;
            r_out_seq   <= r_ord_seq;
            r_ord_seq   <= r_ord_seq + SEQ_WIDTH'(1);
            r_timer     <= TW'(ORDER_TIMEOUT - 1);
            r_state     <= ST_WAIT_ACK;
          end else if (kill_switch) begin
            // Only permitted withdrawal of a request: the entry is discarded.
            r_ord_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_WAIT_ACK: begin
          // A matching ack beats a simultaneous timeout; kill does not abort here.
          if (w_ack_match) begin
            r_busy  <= 1'b0;
            r_cool  <= CW'(COOLDOWN_CYCLES);
            r_state <= ST_AFTER_ORDER;
          end else if (w_timer_done) begin
            r_timeout_pulse <= 1'b1;
            r_busy          <= 1'b0;
            r_cool          <= CW'(COOLDOWN_CYCLES);
            r_timer         <= '0;
            r_state         <= ST_AFTER_ORDER;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (r_cool <= CW'(1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_cool <= r_cool - CW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ord_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ord_valid      = r_ord_valid;
  assign ord_path       = r_ord_path;
  assign ord_profit_bps = r_ord_profit;
  assign ord_seq        = r_ord_seq;
  assign busy           = r_busy;
  assign timeout_pulse  = r_timeout_pulse;
  assign tokens         = r_tokens;
  assign orders_sent    = r_orders_sent;
  assign drops_low      = r_drops_low;
  assign drops_full     = r_drops_full;
  assign timeouts       = r_timeouts;

endmodule

// File: tb/tb_arb_order_trigger.sv
// Directed bench for arb_order_trigger with shortened timing parameters:
// refill every 1000 cycles, 40-cycle ack timeout, 5-cycle cooldown, 3-bit seq.
module tb_arb_order_trigger;
  import arb_trigger_pkg::*;

  localparam int REFILL  = 1000;
  localparam int TIMEOUT = 40;
  localparam int COOL    = 5;
  localparam int SW      = 3;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        kill_switch;
  logic        opp_valid;
  logic [31:0] opp_profit_bps;
  logic [2:0]  opp_path;
  logic        ord_valid;
  logic        ord_ready;
  logic [2:0]  ord_path;
  logic [31:0] ord_profit_bps;
  logic [SW-1:0] ord_seq;
  logic        ack_valid;
  logic [SW-1:0] ack_seq;
  logic        busy;
  logic        timeout_pulse;
  logic [3:0]  tokens;
  logic [31:0] orders_sent;
  logic [31:0] drops_low;
  logic [31:0] drops_full;
  logic [31:0] timeouts;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit ok;

  arb_order_trigger #(
    .FIFO_DEPTH          (4),
    .MIN_PROFIT_BPS      (10),
    .TOKEN_MAX           (8),
    .TOKEN_REFILL_CYCLES (REFILL),
    .ORDER_TIMEOUT       (TIMEOUT),
    .COOLDOWN_CYCLES     (COOL),
    .SEQ_WIDTH           (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .kill_switch    (kill_switch),
    .opp_valid      (opp_valid),
    .opp_profit_bps (opp_profit_bps),
    .opp_path       (opp_path),
    .ord_valid      (ord_valid),
    .ord_ready      (ord_ready),
    .ord_path       (ord_path),
    .ord_profit_bps (ord_profit_bps),
    .ord_seq        (ord_seq),
    .ack_valid      (ack_valid),
    .ack_seq        (ack_seq),
    .busy           (busy),
    .timeout_pulse  (timeout_pulse),
    .tokens         (tokens),
    .orders_sent    (orders_sent),
    .drops_low      (drops_low),
    .drops_full     (drops_full),
    .timeouts       (timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release (edge 1 is the first edge that sees rst low).
  always @(posedge clk) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    int n;
    n = 0;
    found = ord_valid;
    while (!found && n < budget) begin
      step(1);
      n++;
      found = ord_valid;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; kill_switch = 1'b0; opp_valid = 1'b0;
    ord_ready = 1'b0; ack_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; kill_switch = 1'b0; opp_valid = 1'b0;
    opp_profit_bps = 32'd0; opp_path = 3'd0; ord_ready = 1'b0;
    ack_valid = 1'b0; ack_seq = '0;
    step(3);

    // Reset state
    check("rst_valid",   64'(ord_valid), 64'(0));
    check("rst_busy",    64'(busy), 64'(0));
    check("rst_tokens",  64'(tokens), 64'(8));
    check("rst_seq",     64'(ord_seq), 64'(0));
    check("rst_sent",    64'(orders_sent), 64'(0));
    check("rst_dlow",    64'(drops_low), 64'(0));
    check("rst_dfull",   64'(drops_full), 64'(0));
    check("rst_tmo",     64'(timeouts), 64'(0));
    check("rst_pulse",   64'(timeout_pulse), 64'(0));
    check("rst_path",    64'(ord_path), 64'(0));
    check("rst_profit",  64'(ord_profit_bps), 64'(0));
    rst = 1'b0;

    // Basic order: valid two cycles after the strobe, handshake, ack, cooldown
    ord_ready = 1'b1;
    opp_valid = 1'b1; opp_profit_bps = 32'd25; opp_path = PATH_CB_BN;
    step(1);
    opp_valid = 1'b0;
    check("lat_n1_valid", 64'(ord_valid), 64'(0));
    step(1);
    check("lat_n2_valid", 64'(ord_valid), 64'(1));
    check("basic_path",   64'(ord_path), 64'(1));
    check("basic_profit", 64'(ord_profit_bps), 64'(25));
    check("basic_seq",    64'(ord_seq), 64'(0));
    check("basic_busy",   64'(busy), 64'(1));
    step(1);
    check("hs_valid",  64'(ord_valid), 64'(0));
    check("hs_sent",   64'(orders_sent), 64'(1));
    check("hs_tokens", 64'(tokens), 64'(7));
    check("hs_seq",    64'(ord_seq), 64'(1));
    check("hs_busy",   64'(busy), 64'(1));
    ack_valid = 1'b1; ack_seq = 3'd5;
    step(1);
    check("ack_mismatch_busy", 64'(busy), 64'(1));
    ack_seq = 3'd0;
    step(1);
    ack_valid = 1'b0;
    check("ack_match_busy", 64'(busy), 64'(0));
    // Next opportunity queued during cooldown: valid exactly COOL+2 after ack cycle
    ord_ready = 1'b0;
    opp_valid = 1'b1; opp_profit_bps = 32'd30; opp_path = PATH_BN_CB;
    step(1);
    opp_valid = 1'b0;
    step(4);
    check("cool_no_valid", 64'(ord_valid), 64'(0));
    step(1);
    check("cool_issue_valid", 64'(ord_valid), 64'(1));
    check("cool_issue_path",  64'(ord_path), 64'(2));
    check("cool_issue_seq",   64'(ord_seq), 64'(1));
    // Hold under backpressure while two more entries queue
    opp_valid = 1'b1; opp_profit_bps = 32'd40; opp_path = PATH_BN_OKX;
    step(1);
    opp_profit_bps = 32'd50;
    step(1);
    opp_valid = 1'b0;
    check("hold_valid",  64'(ord_valid), 64'(1));
    check("hold_profit", 64'(ord_profit_bps), 64'(30));
    // Kill in ISSUE: withdraw, flush queue, suppress the concurrent push silently
    kill_switch = 1'b1;
    opp_valid = 1'b1; opp_profit_bps = 32'd60;
    step(1);
    opp_valid = 1'b0;
    check("kill_valid", 64'(ord_valid), 64'(0));
    check("kill_busy",  64'(busy), 64'(0));
    check("kill_dfull", 64'(drops_full), 64'(0));
    kill_switch = 1'b0; ord_ready = 1'b1;
    step(6);
    check("kill_flushed_valid", 64'(ord_valid), 64'(0));
    check("kill_flushed_sent",  64'(orders_sent), 64'(1));

    // Threshold, full queue, timeout
    do_reset();
    opp_valid = 1'b1; opp_profit_bps = 32'd9; opp_path = PATH_CB_BN;
    step(1);
    opp_valid = 1'b0;
    check("low_drops", 64'(drops_low), 64'(1));
    step(2);
    check("low_not_queued", 64'(ord_valid), 64'(0));
    for (int i = 0; i < 6; i++) begin
      opp_valid = 1'b1; opp_profit_bps = 32'(10 + i);
      step(1);
    end
    opp_valid = 1'b0;
    check("full_drops",  64'(drops_full), 64'(1));
    check("full_dlow",   64'(drops_low), 64'(1));
    check("full_valid",  64'(ord_valid), 64'(1));
    check("full_profit", 64'(ord_profit_bps), 64'(10));
    ord_ready = 1'b1;
    step(1);
    check("tmo_hs_sent", 64'(orders_sent), 64'(1));
    ord_ready = 1'b0;
    step(TIMEOUT - 2);
    check("tmo_early_pulse", 64'(timeout_pulse), 64'(0));
    step(1);
    check("tmo_pulse",   64'(timeout_pulse), 64'(1));
    check("tmo_count",   64'(timeouts), 64'(1));
    check("tmo_busy",    64'(busy), 64'(0));
    step(1);
    check("tmo_pulse_once", 64'(timeout_pulse), 64'(0));
    wait_valid(20, ok);
    check("tmo_next_found",  64'(ok), 64'(1));
    check("tmo_next_profit", 64'(ord_profit_bps), 64'(11));
    check("tmo_next_seq",    64'(ord_seq), 64'(1));
    ord_ready = 1'b1;
    step(1);
    ord_ready = 1'b0;
    step(TIMEOUT - 2);
    ack_valid = 1'b1; ack_seq = 3'd1;
    step(1);
    ack_valid = 1'b0;
    check("ackwin_pulse", 64'(timeout_pulse), 64'(0));
    check("ackwin_count", 64'(timeouts), 64'(1));
    check("ackwin_busy",  64'(busy), 64'(0));
    step(1);
    check("ackwin_pulse_late", 64'(timeout_pulse), 64'(0));
    // enable low blocks issue; queue keeps 12,13,14
    enable = 1'b0;
    step(15);
    check("enable_block", 64'(ord_valid), 64'(0));
    enable = 1'b1;
    wait_valid(5, ok);
    check("enable_found",  64'(ok), 64'(1));
    check("enable_profit", 64'(ord_profit_bps), 64'(12));

    // Rate limit and sequence wrap (3-bit seq wraps after 8 orders)
    do_reset();
    ord_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opp_valid = 1'b1; opp_profit_bps = 32'(100 + i); opp_path = PATH_BN_CB;
      step(1);
      opp_valid = 1'b0;
      wait_valid(20, ok);
      check("rate_found", 64'(ok), 64'(1));
      check("rate_seq",   64'(ord_seq), 64'(i));
      step(1);
      ack_valid = 1'b1; ack_seq = SW'(i);
      step(1);
      ack_valid = 1'b0;
    end
    step(6);
    check("rate_tokens0", 64'(tokens), 64'(0));
    check("rate_sent8",   64'(orders_sent), 64'(8));
    check("wrap_seq",     64'(ord_seq), 64'(0));
    opp_valid = 1'b1; opp_profit_bps = 32'd200; opp_path = PATH_BN_OKX;
    step(1);
    opp_valid = 1'b0;
    step(20);
    check("rate_hold", 64'(ord_valid), 64'(0));
    wait_valid(1200, ok);
    check("refill_found",  64'(ok), 64'(1));
    check("refill_edge",   64'(edge_cnt), 64'(REFILL + 1));
    check("refill_tokens", 64'(tokens), 64'(1));
    check("refill_seq",    64'(ord_seq), 64'(0));
    check("refill_profit", 64'(ord_profit_bps), 64'(200));
    step(1);
    check("refill_consumed", 64'(tokens), 64'(0));
    // Kill during WAIT_ACK does not abort; matching ack still honoured
    kill_switch = 1'b1;
    step(2);
    check("kill_wait_busy", 64'(busy), 64'(1));
    ack_valid = 1'b1; ack_seq = 3'd0;
    step(1);
    ack_valid = 1'b0;
    check("kill_wait_ack", 64'(busy), 64'(0));
    kill_switch = 1'b0;

    // Reset mid-WAIT_ACK
    do_reset();
    ord_ready = 1'b1;
    opp_valid = 1'b1; opp_profit_bps = 32'd77; opp_path = PATH_CB_BN;
    step(1);
    opp_valid = 1'b0;
    wait_valid(5, ok);
    step(1);
    check("midrst_pre_busy", 64'(busy), 64'(1));
    check("midrst_pre_tok",  64'(tokens), 64'(7));
    rst = 1'b1;
    step(1);
    check("midrst_valid",  64'(ord_valid), 64'(0));
    check("midrst_busy",   64'(busy), 64'(0));
    check("midrst_tokens", 64'(tokens), 64'(8));
    check("midrst_sent",   64'(orders_sent), 64'(0));
    check("midrst_seq",    64'(ord_seq), 64'(0));
    check("midrst_path",   64'(ord_path), 64'(0));
    check("midrst_profit", 64'(ord_profit_bps), 64'(0));
    rst = 1'b0;
    step(TIMEOUT + 5);
    check("midrst_forgot", 64'(timeouts), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
